// File: rtl/mem_ctrl.sv
// mem_ctrl: DEPTHx32 word memory behind a wait-stated request FSM.
// In: clk, reset(async low), Read, Write, addr, wdata.
// Out: rdata, mem_ready (1-cycle pulse), busy, err (sticky conflict).
module mem_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE,
    HOLD
  } state_t;

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  state_t state, state_nx;
  logic [3:0] wcnt, wcnt_nx;

  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic              lat_wr;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic one_req;
  logic both_req;
  logic accept;
  logic conflict;

  assign one_req  = Read ^ Write;
  assign both_req = Read & Write;
  assign accept   = (state == IDLE) & one_req;
  assign conflict = (state == IDLE) & both_req;

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    unique case (state)
      IDLE: begin
        if (one_req) begin
          if (WAIT_STATES == 0) begin
            state_nx = ACCESS;
          end else begin
            state_nx = WAIT;
            wcnt_nx  = WS_LOAD;
          end
        end else if (both_req) begin
          state_nx = HOLD;
        end
      end
      WAIT: begin
        if (wcnt == 4'd0) state_nx = ACCESS;
        else              wcnt_nx  = wcnt - 4'd1;
      end
      ACCESS: state_nx = DONE;
      DONE:   state_nx = HOLD;
      // Wait for the level request to drop so it
      // is never serviced a second time.
      HOLD: begin
        if (!Read && !Write) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      busy      <= 1'b0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      lat_wr    <= 1'b0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      busy      <= (state_nx != IDLE);
      mem_ready <= (state_nx == DONE);
      if (accept) begin
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_wr    <= Write;
        err       <= 1'b0;
      end else if (conflict) begin
        err <= 1'b1;
      end
      if (state == ACCESS && !lat_wr) begin
        rdata <= mem[lat_addr];
      end
    end
  end

  // Array has no reset; an abort before ACCESS never
  // reaches this write because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (state == ACCESS && lat_wr) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl.
// Two instances: WAIT_STATES=2 (dut) and WAIT_STATES=0 (dut0).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 0, wr = 0, rd0 = 0, wr0 = 0;
  logic [8:0]  ad = 0, ad0 = 0;
  logic [31:0] wd = 0, wd0 = 0;
  logic [31:0] rdata, rdata0;
  logic        mem_ready, busy, err;
  logic        mr0, busy0, err0;

  int errs = 0;
  int checks = 0;

  int lat, bcnt, rcnt;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(9), .DEPTH(512), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .Read(rd), .Write(wr),
    .addr(ad), .wdata(wd), .rdata(rdata),
    .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  mem_ctrl #(.ADDR_W(9), .DEPTH(512), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .Read(rd0), .Write(wr0),
    .addr(ad0), .wdata(wd0), .rdata(rdata0),
    .mem_ready(mr0), .busy(busy0), .err(err0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit u0, input logic r, input logic w,
                       input logic [8:0] a, input logic [31:0] d);
    if (u0) begin
      rd0 = r; wr0 = w; ad0 = a; wd0 = d;
    end else begin
      rd = r; wr = w; ad = a; wd = d;
    end
  endtask

  // Issue one request; hold it at least 'hold' edges and until
  // mem_ready (or err) is seen. addr/wdata are scrambled right
  // after the accept edge. lat = edge index of first mem_ready.
  task automatic op(input bit u0, input logic r, input logic w,
                    input logic [8:0] a, input logic [31:0] d,
                    input int hold, output int l,
                    output int bc, output int rc);
    bit dropped;
    logic b, m, e;
    dropped = 0;
    l = 0; bc = 0; rc = 0;
    @(negedge clk);
    drive(u0, r, w, a, d);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      b = u0 ? busy0 : busy;
      m = u0 ? mr0 : mem_ready;
      e = u0 ? err0 : err;
      if (i == 1) drive(u0, r, w, ~a, ~d);
      if (b) bc++;
      if (m) begin
        rc++;
        if (l == 0) l = i;
      end
      if (dropped && !b) break;
      if (!dropped && (l != 0 || e) && i >= hold) begin
        @(negedge clk);
        drive(u0, 1'b0, 1'b0, 9'h0, 32'h0);
        dropped = 1;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", {31'd0, mem_ready}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    @(negedge clk) reset = 1'b1;

    op(0, 0, 1, 9'h020, 32'h0000_0055, 0, lat, bcnt, rcnt);
    chk("wr_lat", lat, 4);
    chk("wr_busy", bcnt, 5);
    chk("wr_pulses", rcnt, 1);

    op(0, 0, 1, 9'h021, 32'h0000_011B, 0, lat, bcnt, rcnt);
    chk("wr_no_rdata", rdata, 32'h0);

    op(0, 1, 0, 9'h020, 32'h0, 0, lat, bcnt, rcnt);
    chk("rd20_lat", lat, 4);
    chk("rd20_data", rdata, 32'h0000_0055);

    op(0, 1, 0, 9'h021, 32'h0, 10, lat, bcnt, rcnt);
    chk("hold_pulses", rcnt, 1);
    chk("hold_lat", lat, 4);
    chk("hold_busy", bcnt, 10);
    chk("hold_data", rdata, 32'h0000_011B);

    op(0, 0, 1, 9'h030, 32'h1234_5678, 0, lat, bcnt, rcnt);
    chk("wr_keeps_rdata", rdata, 32'h0000_011B);
    op(0, 1, 0, 9'h030, 32'h0, 0, lat, bcnt, rcnt);
    chk("raw_data", rdata, 32'h1234_5678);

    op(0, 1, 1, 9'h020, 32'hFFFF_FFFF, 0, lat, bcnt, rcnt);
    chk("cf_pulses", rcnt, 0);
    chk("cf_err", {31'd0, err}, 32'h1);
    chk("cf_busy", bcnt, 1);

    op(0, 1, 0, 9'h020, 32'h0, 0, lat, bcnt, rcnt);
    chk("cf_array", rdata, 32'h0000_0055);
    chk("cf_err_clr", {31'd0, err}, 32'h0);
    chk("cf_rd_lat", lat, 4);

    op(0, 1, 1, 9'h000, 32'h0, 0, lat, bcnt, rcnt);
    chk("cf2_err", {31'd0, err}, 32'h1);
    @(negedge clk) reset = 1'b0;
    #1 chk("rst_err_clr", {31'd0, err}, 32'h0);
    @(negedge clk) reset = 1'b1;

    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'h1FF, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("ab_busy", {31'd0, busy}, 32'h1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("ab_rdata", rdata, 32'h0);
    chk("ab_busy0", {31'd0, busy}, 32'h0);
    chk("ab_ready", {31'd0, mem_ready}, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 9'h1FF, 32'h0);
    @(negedge clk) reset = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = i;
        break;
      end
    end
    chk("ab_rel_lat", lat, 4);
    chk("ab_array", rdata, 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
    repeat (3) @(posedge clk);

    op(1, 0, 1, 9'h000, 32'hA5A5_0001, 0, lat, bcnt, rcnt);
    chk("w0_lat", lat, 2);
    chk("w0_busy", bcnt, 3);
    op(1, 0, 1, 9'h1FF, 32'h0BAD_0BAD, 0, lat, bcnt, rcnt);
    op(1, 1, 0, 9'h000, 32'h0, 0, lat, bcnt, rcnt);
    chk("r0_lat", lat, 2);
    chk("r0_pulses", rcnt, 1);
    chk("r0_data", rdata0, 32'hA5A5_0001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
